// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among 4 byte requesters
// Ports: clk/rst_n (async active-low); req[3:0] level requests with req_data byte lanes [8i+7:8i];
// ack one-hot capture pulse; tx_en_sig/tx_data drive the transmitter for BPS*10+1 clocks;
// busy high in SEND/GAP; done pulses the cycle after tx_en_sig falls; gnt_id is the last grant.
module uart_tx_sched #(
  parameter int BPS     = 434,
  parameter int GAP_CLK = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic        tx_en_sig,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  gnt_id
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
  localparam logic [15:0] FRAME_LAST = 16'(BPS * 10);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CLK > 0 ? GAP_CLK - 1 : 0);
  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d, gnt_q, gnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  ack_q, ack_d;
  logic        tx_en_q, tx_en_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  rot_w;
  logic [1:0]  off, win;
  // rotate requests so bit 0 is the pointer position; lowest set bit is the winner
  assign rot_w = {req, req} >> ptr_q;
  assign off   = rot_w[0] ? 2'd0 : rot_w[1] ? 2'd1 : rot_w[2] ? 2'd2 : 2'd3;
  assign win   = ptr_q + off;
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ack_d     = 4'b0000;
    tx_en_d   = tx_en_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    gnt_d     = gnt_q;
    case (state_q)
      IDLE: begin
        tx_en_d = 1'b0;
        busy_d  = 1'b0;
        if (|req) begin
          state_d   = SEND;
          tx_data_d = req_data[{win, 3'b000} +: 8];
          gnt_d     = win;
          ack_d     = 4'b0001 << win;
          tx_en_d   = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = 16'd0;
          ptr_d     = win + 2'd1;
        end
      end
      SEND: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == FRAME_LAST) begin
          tx_en_d = 1'b0;
          done_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = GAP_CLK == 0 ? IDLE : GAP;
          busy_d  = GAP_CLK != 0;
        end
      end
      GAP: begin
        tx_en_d = 1'b0;
        cnt_d   = cnt_q + 16'd1;
        if (cnt_q == GAP_LAST) begin
          busy_d  = 1'b0;
          cnt_d   = 16'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_en_d = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = 16'd0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= 16'd0;
      ack_q     <= 4'b0000;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gnt_q     <= gnt_d;
    end
  end
  assign ack       = ack_q;
  assign tx_en_sig = tx_en_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign gnt_id    = gnt_q;
endmodule
